// File: rtl/nco_sine_lut.sv
// nco_sine_lut: NCO phase-to-amplitude stage. Quarter-wave sine ROM with symmetry fold, 3-cycle latency.
// Optional phase dither before truncation is enabled by defining NCO_PHASE_DITHER_EN.
module nco_sine_lut #(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 8,
  parameter int AMP_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [PHASE_W-1:0] phase_in,
  output logic               valid_out,
  output logic [AMP_W-1:0]   sin_out
);

  localparam int ROM_N = 1 << LUT_AW;
  localparam int D     = PHASE_W - 2 - LUT_AW;

  // Half-LSB offset keeps the table symmetric so the fold needs no edge cases.
  function automatic logic [AMP_W-1:0] rom_entry(input int k);
    real amp;
    real x;
    int  r;
    amp = real'((2 ** (AMP_W - 1)) - 1);
    x   = amp * $sin(3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(ROM_N));
    r   = $rtoi(x + 0.5);
    return r[AMP_W-1:0];
  endfunction

  logic [AMP_W-1:0] rom [ROM_N];

  for (genvar i = 0; i < ROM_N; i++) begin : g_rom
    assign rom[i] = rom_entry(i);
  end

  logic [PHASE_W-1:0] phase_eff;

`ifdef NCO_PHASE_DITHER_EN
  localparam logic [31:0] LFSR_SEED = 32'hACE1_2468;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (valid_in) lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
    phase_eff = phase_in + {{(PHASE_W-D){1'b0}}, lfsr_q[D-1:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign phase_eff = phase_in;
`endif

  logic unused_lsbs;
  assign unused_lsbs = ^phase_eff[D-1:0];

  logic [1:0]        quad_q, quad_d;
  logic [LUT_AW-1:0] idx_q, idx_d;
  logic              v1_q, v1_d;
  logic [AMP_W-1:0]  rom_q, rom_d;
  logic              neg_q, neg_d;
  logic              v2_q, v2_d;
  logic [AMP_W-1:0]  sin_q, sin_d;
  logic              v3_q, v3_d;
  logic [LUT_AW-1:0] addr;

  // Data registers only load behind a valid bit, so sin_out holds across gaps.
  always_comb begin
    quad_d = quad_q;
    idx_d  = idx_q;
    if (valid_in) {quad_d, idx_d} = phase_eff[PHASE_W-1 -: LUT_AW+2];
    v1_d = valid_in;

    addr  = quad_q[0] ? ~idx_q : idx_q;
    rom_d = rom_q;
    neg_d = neg_q;
    if (v1_q) begin
      rom_d = rom[addr];
      neg_d = quad_q[1];
    end
    v2_d = v1_q;

    sin_d = sin_q;
    if (v2_q) sin_d = neg_q ? -rom_q : rom_q;
    v3_d = v2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quad_q <= '0;
      idx_q  <= '0;
      v1_q   <= 1'b0;
      rom_q  <= '0;
      neg_q  <= 1'b0;
      v2_q   <= 1'b0;
      sin_q  <= '0;
      v3_q   <= 1'b0;
    end else begin
      quad_q <= quad_d;
      idx_q  <= idx_d;
      v1_q   <= v1_d;
      rom_q  <= rom_d;
      neg_q  <= neg_d;
      v2_q   <= v2_d;
      sin_q  <= sin_d;
      v3_q   <= v3_d;
    end
  end

  assign valid_out = v3_q;
  assign sin_out   = sin_q;

endmodule

// File: tb/tb_nco_sine_lut.sv
// tb_nco_sine_lut: directed table-driven bench for nco_sine_lut with a full-circle sine model.
// Tolerates the +1 index offset of NCO_PHASE_DITHER_EN when that macro is defined.
module tb_nco_sine_lut;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] phase_in;
  logic        valid_out;
  logic [15:0] sin_out;

  int checks = 0;
  int errors = 0;
  logic [15:0] last_exp;

  nco_sine_lut #(.PHASE_W(32), .LUT_AW(8), .AMP_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .phase_in  (phase_in),
    .valid_out (valid_out),
    .sin_out   (sin_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] phase;
    logic [15:0] exp;
  } vec_t;

  // Reference: sample the whole circle at the centre of each of the 1024 phase bins.
  function automatic logic [15:0] model(input logic [31:0] ph);
    int  idx;
    real x;
    int  r;
    idx = int'(ph[31:22]);
    x   = 32767.0 * $sin(2.0 * 3.14159265358979323846 * (real'(idx) + 0.5) / 1024.0);
    if (x >= 0.0) r = $rtoi(x + 0.5);
    else          r = -$rtoi(-x + 0.5);
    return r[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] p);
    rst      = r;
    valid_in = v;
    phase_in = p;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkSample(input string name, input logic [15:0] act,
                             input logic [31:0] ph, input logic [15:0] exp);
    checks++;
`ifdef NCO_PHASE_DITHER_EN
    if (act !== model(ph) && act !== model(ph + 32'h0040_0000)) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h or %0h", name, act, model(ph),
               model(ph + 32'h0040_0000));
    end
`else
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
`endif
  endtask

  task automatic checkHold(input string name);
`ifndef NCO_PHASE_DITHER_EN
    checkOutput(name, 32'(sin_out), 32'(last_exp));
`endif
  endtask

  localparam int NV = 11;
  localparam int NS = 1030;

  vec_t        vecs [NV];
  logic        sw_vld [NS];
  logic [31:0] sw_ph  [NS];
  logic [15:0] sw_out [1024];
  logic        sw_got [1024];

  initial begin
    int in_cnt;
    int out_cnt;

    vecs[0]  = '{1'b1, 32'h0000_0000, 16'h0065};
    vecs[1]  = '{1'b0, 32'h1234_5678, 16'h0000};
    vecs[2]  = '{1'b1, 32'h3FC0_0000, 16'h7FFF};
    vecs[3]  = '{1'b1, 32'h4000_0000, 16'h7FFF};
    vecs[4]  = '{1'b1, 32'h8000_0000, 16'hFF9B};
    vecs[5]  = '{1'b1, 32'hC000_0000, 16'h8001};
    vecs[6]  = '{1'b1, 32'hFFFF_FFFF, 16'hFF9B};
    vecs[7]  = '{1'b0, 32'h4000_0000, 16'h0000};
    vecs[8]  = '{1'b1, 32'h2000_0000, model(32'h2000_0000)};
    vecs[9]  = '{1'b1, 32'h7FFF_FFFF, 16'h0065};
    vecs[10] = '{1'b1, 32'hBFFF_FFFF, 16'h8001};

    // Reset held with valid_in high: nothing may emerge.
    applyStimulus(1'b1, 1'b1, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("reset_valid_out", 32'(valid_out), 32'd0);
      checkOutput("reset_sin_out", 32'(sin_out), 32'd0);
    end
    last_exp = 16'h0000;

    for (int c = 0; c < NV + 2; c++) begin
      if (c < NV) applyStimulus(1'b0, vecs[c].vld, vecs[c].phase);
      else        applyStimulus(1'b0, 1'b0, 32'h0);
      tick();
      if (c < 2) begin
        checkOutput("vec_lead_valid", 32'(valid_out), 32'd0);
      end else begin
        checkOutput($sformatf("vec%0d_valid", c - 2), 32'(valid_out), 32'(vecs[c-2].vld));
        if (vecs[c-2].vld) begin
          checkSample($sformatf("vec%0d_sin", c - 2), sin_out, vecs[c-2].phase, vecs[c-2].exp);
          last_exp = vecs[c-2].exp;
        end else begin
          checkHold($sformatf("vec%0d_hold", c - 2));
        end
      end
    end

    // One-index-per-cycle sweep across a full circle and past the wrap, with gaps.
    for (int c = 0; c < NS; c++) begin
      sw_vld[c] = (c % 7) != 6;
      sw_ph[c]  = 32'(c) * 32'h0040_0000;
    end
    for (int n = 0; n < 1024; n++) sw_got[n] = 1'b0;
    in_cnt  = 0;
    out_cnt = 0;
    for (int c = 0; c < NS + 2; c++) begin
      if (c < NS) begin
        applyStimulus(1'b0, sw_vld[c], sw_ph[c]);
        if (sw_vld[c]) in_cnt++;
      end else begin
        applyStimulus(1'b0, 1'b0, 32'h0);
      end
      tick();
      if (c >= 2) begin
        int j;
        j = c - 2;
        checkOutput($sformatf("sweep%0d_valid", j), 32'(valid_out), 32'(sw_vld[j]));
        if (valid_out) out_cnt++;
        if (sw_vld[j]) begin
          checkSample($sformatf("sweep%0d_sin", j), sin_out, sw_ph[j], model(sw_ph[j]));
          last_exp = model(sw_ph[j]);
          if (j < 1024) begin
            sw_out[j] = sin_out;
            sw_got[j] = 1'b1;
          end
        end else begin
          checkHold($sformatf("sweep%0d_hold", j));
        end
      end
    end
    checkOutput("sweep_count", 32'(out_cnt), 32'(in_cnt));
`ifndef NCO_PHASE_DITHER_EN
    for (int n = 0; n < 512; n++) begin
      if (sw_got[n] && sw_got[n+512])
        checkOutput($sformatf("sym%0d", n), 32'(sw_out[n+512]), 32'(16'(-sw_out[n])));
    end
`endif

    // Mid-stream reset pulse flushes everything in flight.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h1000_0000 * 32'(i + 1));
      tick();
    end
    applyStimulus(1'b1, 1'b1, 32'h5000_0000);
    tick();
    checkOutput("flush_valid_out", 32'(valid_out), 32'd0);
    checkOutput("flush_sin_out", 32'(sin_out), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      tick();
      checkOutput("post_flush_valid", 32'(valid_out), 32'd0);
      checkOutput("post_flush_sin", 32'(sin_out), 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 32'h4000_0000);
    tick();
    checkOutput("restart_lat0", 32'(valid_out), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("restart_lat1", 32'(valid_out), 32'd0);
    tick();
    checkOutput("restart_valid", 32'(valid_out), 32'd1);
    checkSample("restart_sin", sin_out, 32'h4000_0000, 16'h7FFF);
    tick();
    checkOutput("restart_single", 32'(valid_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nco_sine_lut.md
Name: nco_sine_lut

Overview:
- Phase-to-amplitude stage of the NCO.
- Sits directly downstream of the phase accumulator, which is built around the registered N-bit adder.
- Takes the accumulated phase word, truncates it, folds it into a quarter-wave sine ROM using symmetry, and emits a signed sine sample per valid phase.
- Fully pipelined, one sample per clock, fixed latency.

Parameters:
- PHASE_W, 32: accumulator phase word width.
- LUT_AW, 8: quarter-wave ROM address width (N = 2^LUT_AW entries).
- AMP_W, 16: signed output amplitude width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  phase_in is valid this cycle.
- phase_in  input  PHASE_W  accumulated phase, unsigned, full circle = 2^PHASE_W.
- valid_out  output  1  sin_out is valid this cycle.
- sin_out  output  AMP_W  two's-complement sine sample.

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset state: sin_out=0, valid_out=0, all pipeline registers and valid bits cleared.
- rst asserted mid-stream flushes all in-flight samples. No valid_out appears for phases accepted before rst.
- Phase slicing:
  - q = phase[PHASE_W-1:PHASE_W-2] (quadrant).
  - k = phase[PHASE_W-3:PHASE_W-2-LUT_AW] (index).
  - Lower bits are discarded (truncation, no rounding).
- ROM contents: ROM[k] = round((2^(AMP_W-1)-1) * sin(pi/2 * (k+0.5)/N)), k = 0..N-1. Values are unsigned and non-negative. The half-LSB offset makes the fold exact without a special case at quadrant edges.
- Fold rules:
  - q=0: addr=k, positive.
  - q=1: addr=N-1-k (bitwise ~k), positive.
  - q=2: addr=k, negated.
  - q=3: addr=~k, negated.
- Pipeline, 3 stages, latency 3 cycles from valid_in to valid_out:
  - S1 registers the truncated phase fields (q, k) and valid.
  - S2 registers the ROM read at the folded address, plus the sign bit and valid.
  - S3 registers sin_out = sign ? -rom : rom (AMP_W-bit two's complement), and valid_out.
- Negation cannot overflow, because ROM max = 2^(AMP_W-1)-1.
- valid handling:
  - No backpressure; accepts a new phase every cycle.
  - Valid bits shift unconditionally, so gaps in valid_in reappear exactly 3 cycles later on valid_out.
  - When valid_out=0, sin_out holds its last value (data registers load only when the stage's valid is 1).
- Phase wrap-around (e.g. 0xFFFF_FFFF -> 0x0000_0000) needs no special handling; it is inherent in the modulo-2^PHASE_W quadrant decode.
- ROM is implemented as a synchronous-read constant array initialised from a generated table. No runtime trig.

Optional Feature:
- Macro: NCO_PHASE_DITHER_EN.
- Defined:
  - A 32-bit Galois LFSR (taps x^32+x^22+x^2+x+1) is seeded to 32'hACE1_2468 on rst.
  - It advances only on cycles with valid_in=1.
  - Before truncation in S1, phase_eff = phase_in + lfsr[D-1:0] mod 2^PHASE_W, where D = PHASE_W-2-LUT_AW.
  - Latency is unchanged.
  - Effect: truncation spurs are spread into the noise floor; each output is within ±1 ROM index of the undithered result.
- Not defined: no LFSR is instantiated; phase_eff = phase_in (pure truncation). Outputs are bit-exact with the ROM fold rules above.

Test Plan:
- rst=1 for 4 cycles with valid_in=1 -> valid_out=0 and sin_out=0 throughout; first valid_out exactly 3 cycles after the first valid_in following rst release.
- phase_in=0x0000_0000, valid_in for 1 cycle -> 3 cycles later valid_out=1, sin_out=101 (0x0065).
- phase_in=0x3FC0_0000 then 0x4000_0000 -> sin_out=32767, 32767 on consecutive cycles (peak across the quadrant 0/1 boundary).
- phase_in=0x8000_0000 then 0xC000_0000 -> sin_out=-101 (0xFF9B), then -32767 (0x8001).
- Continuous sweep of +0x0040_0000 per cycle for 1024 cycles, with valid_in dropped every 7th cycle:
  - one output per valid, gap pattern reproduced 3 cycles late;
  - out[n+512] = -out[n];
  - outputs wrap cleanly past 0xFFC0_0000 -> 0x0000_0000.
- Stream running, rst pulsed 1 cycle -> next cycle valid_out=0, sin_out=0; no stale samples emerge afterwards. With NCO_PHASE_DITHER_EN, each sample stays within ±1 index of its undithered value.
